// File: rtl/param_multiplier_pkg.sv
// Shared definitions for the param_multiplier datapath leaf.
// Product width helper keeps the top and the reduction array in agreement.
package param_multiplier_pkg;

   function automatic int unsigned prod_width(input int unsigned w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/param_mult_pp_array.sv
// Combinational partial-product array: one ripple-carry add row per bit of b,
// accumulating into a full-precision 2*WIDTH sum.
module param_mult_pp_array
   import param_multiplier_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]                  a,
   input  logic [WIDTH-1:0]                  b,
   output logic [prod_width(WIDTH)-1:0]      product
);

   localparam int unsigned PW = prod_width(WIDTH);

   logic [PW-1:0] acc;
   logic [PW-1:0] pp;
   logic          cy;
   logic          cy_next;

   always_comb begin
      acc     = '0;
      pp      = '0;
      cy      = 1'b0;
      cy_next = 1'b0;
      for (int unsigned r = 0; r < WIDTH; r++) begin
         pp = b[r] ? ({{WIDTH{1'b0}}, a} << r) : '0;
         cy = 1'b0;
         // Bit-serial ripple across the row; carry out of the top bit is always zero.
         for (int unsigned c = 0; c < PW; c++) begin
            cy_next = (acc[c] & pp[c]) | (cy & (acc[c] ^ pp[c]));
            acc[c]  = acc[c] ^ pp[c] ^ cy;
            cy      = cy_next;
         end
      end
      product = acc;
   end

endmodule

// File: rtl/param_multiplier.sv
// Two-stage pipelined unsigned WIDTH x WIDTH multiplier with full-precision product.
// Stage 1 registers operands, stage 2 registers the reduced product; valid travels alongside.
module param_multiplier
   import param_multiplier_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   input  logic [WIDTH-1:0]                  a,
   input  logic [WIDTH-1:0]                  b,
   output logic                              out_valid,
   output logic [prod_width(WIDTH)-1:0]      product
);

   logic [WIDTH-1:0]             a_q;
   logic [WIDTH-1:0]             b_q;
   logic                         v_q;
   logic [prod_width(WIDTH)-1:0] pp_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         v_q <= 1'b0;
      end else begin
         v_q <= in_valid;
         if (in_valid) begin
            a_q <= a;
            b_q <= b;
         end
      end
   end

   param_mult_pp_array #(.WIDTH(WIDTH)) u_pp_array (
      .a       (a_q),
      .b       (b_q),
      .product (pp_sum)
   );

   // Product only loads on a valid stage-1 slot so it holds the last result across gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         product   <= '0;
      end else begin
         out_valid <= v_q;
         if (v_q) begin
            product <= pp_sum;
         end
      end
   end

endmodule

// File: tb/tb_param_multiplier.sv
// Directed and random checks of param_multiplier at WIDTH = 4, 8 and 16.
module tb_param_multiplier;

   logic clk;
   logic rst_n;

   logic        iv4, iv8, iv16;
   logic [3:0]  a4, b4;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic        ov4, ov8, ov16;
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [31:0] p16;

   int unsigned n_vec;
   int unsigned n_bad;

   // reference pipeline state per instance: 0 -> W4, 1 -> W8, 2 -> W16
   int unsigned cur_p [3];
   logic        cur_v [3];
   int unsigned m_p1  [3];
   logic        m_v1  [3];
   int unsigned m_pr  [3];
   logic        m_ov  [3];

   param_multiplier #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4),
      .out_valid(ov4), .product(p4));
   param_multiplier #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8),
      .out_valid(ov8), .product(p8));
   param_multiplier #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .a(a16), .b(b16),
      .out_valid(ov16), .product(p16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set8(input int unsigned a, input int unsigned b, input logic v);
      a8  = 8'(a);
      b8  = 8'(b);
      iv8 = v;
   endtask

   // drive one pair, then an idle slot; result must appear exactly after the second edge
   task automatic mul8(input string tag, input int unsigned a, input int unsigned b,
                       input int unsigned exp);
      set8(a, b, 1'b1);
      tick();
      expect_eq({tag, "_early_ov"}, 32'(ov8), 32'd0);
      set8(0, 0, 1'b0);
      tick();
      expect_eq({tag, "_ov"}, 32'(ov8), 32'd1);
      expect_eq({tag, "_p"}, 32'(p8), 32'(exp));
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_p1[k] = 0; m_v1[k] = 1'b0; m_pr[k] = 0; m_ov[k] = 1'b0;
      end
   endtask

   task automatic pulse_reset_check(input string tag);
      rst_n = 1'b0;
      #1;
      expect_eq({tag, "_ov4"},  32'(ov4),  32'd0);
      expect_eq({tag, "_p4"},   32'(p4),   32'd0);
      expect_eq({tag, "_ov8"},  32'(ov8),  32'd0);
      expect_eq({tag, "_p8"},   32'(p8),   32'd0);
      expect_eq({tag, "_ov16"}, 32'(ov16), 32'd0);
      expect_eq({tag, "_p16"},  32'(p16),  32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   task automatic rand_drive();
      int unsigned ra, rb;
      ra = $urandom_range(0, 15);     rb = $urandom_range(0, 15);
      a4 = 4'(ra);  b4 = 4'(rb);  iv4 = 1'($urandom_range(0, 3) != 0);
      cur_p[0] = ra * rb;  cur_v[0] = iv4;
      ra = $urandom_range(0, 255);    rb = $urandom_range(0, 255);
      a8 = 8'(ra);  b8 = 8'(rb);  iv8 = 1'($urandom_range(0, 3) != 0);
      cur_p[1] = ra * rb;  cur_v[1] = iv8;
      ra = $urandom_range(0, 65535);  rb = $urandom_range(0, 65535);
      if ($urandom_range(0, 15) == 0) begin
         ra = 65535; rb = 65535;
      end
      a16 = 16'(ra); b16 = 16'(rb); iv16 = 1'($urandom_range(0, 3) != 0);
      cur_p[2] = ra * rb;  cur_v[2] = iv16;
   endtask

   task automatic rand_step();
      tick();
      for (int k = 0; k < 3; k++) begin
         m_ov[k] = m_v1[k];
         if (m_v1[k]) m_pr[k] = m_p1[k];
         m_v1[k] = cur_v[k];
         m_p1[k] = cur_p[k];
      end
      expect_eq("rnd_ov4",  32'(ov4),  32'(m_ov[0]));
      expect_eq("rnd_p4",   32'(p4),   m_pr[0]);
      expect_eq("rnd_ov8",  32'(ov8),  32'(m_ov[1]));
      expect_eq("rnd_p8",   32'(p8),   m_pr[1]);
      expect_eq("rnd_ov16", 32'(ov16), 32'(m_ov[2]));
      expect_eq("rnd_p16",  32'(p16),  m_pr[2]);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      iv4 = 1'b0; iv8 = 1'b0; iv16 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
      model_reset();
      #1;
      expect_eq("rst_ov8", 32'(ov8), 32'd0);
      expect_eq("rst_p8",  32'(p8),  32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      mul8("z00", 0, 0, 0);
      mul8("z01", 0, 1, 0);
      mul8("z10", 1, 0, 0);
      mul8("z11", 1, 1, 1);
      mul8("s5x3", 5, 3, 15);
      mul8("s12x10", 12, 10, 120);
      mul8("s255x1", 255, 1, 255);
      mul8("x254", 254, 254, 16'hFC04);
      mul8("x255", 255, 255, 16'hFE01);
      mul8("x128x2", 128, 2, 256);

      // back-to-back stream with one idle gap
      set8(5, 3, 1'b1);   tick();
      expect_eq("tp0_ov", 32'(ov8), 32'd0);
      set8(7, 9, 1'b1);   tick();
      expect_eq("tp1_ov", 32'(ov8), 32'd1);
      expect_eq("tp1_p",  32'(p8),  32'd15);
      set8(255, 255, 1'b1); tick();
      expect_eq("tp2_ov", 32'(ov8), 32'd1);
      expect_eq("tp2_p",  32'(p8),  32'd63);
      set8(3, 3, 1'b0);   tick();
      expect_eq("tp3_ov", 32'(ov8), 32'd1);
      expect_eq("tp3_p",  32'(p8),  32'd65025);
      set8(2, 2, 1'b1);   tick();
      expect_eq("gap_ov", 32'(ov8), 32'd0);
      expect_eq("gap_p",  32'(p8),  32'd65025);
      set8(0, 0, 1'b0);   tick();
      expect_eq("tp5_ov", 32'(ov8), 32'd1);
      expect_eq("tp5_p",  32'(p8),  32'd4);

      // reset mid-stream discards the in-flight pair
      set8(9, 9, 1'b1);   tick();
      set8(4, 4, 1'b1);   tick();
      expect_eq("pre_rst_p", 32'(p8), 32'd81);
      set8(0, 0, 1'b0);
      pulse_reset_check("mid_rst");
      tick();
      expect_eq("post_rst_ov0", 32'(ov8), 32'd0);
      expect_eq("post_rst_p0",  32'(p8),  32'd0);
      tick();
      expect_eq("post_rst_ov1", 32'(ov8), 32'd0);
      mul8("post_rst", 3, 4, 12);

      // random sweep over all three widths with sporadic resets
      pulse_reset_check("rnd_init");
      for (int n = 0; n < 10000; n++) begin
         rand_drive();
         rand_step();
         if ($urandom_range(0, 499) == 0) pulse_reset_check("rnd_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
